// File: rtl/jk_mod_counter_pkg.sv
// jk_mod_counter_pkg: shared direction encodings and width helper for counter tiles
package jk_mod_counter_pkg;
  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/jk_mod_counter_if.sv
// jk_mod_counter_if: control and status bundle of one counter tile
interface jk_mod_counter_if #(parameter int WIDTH = 4);
  logic             count_enable;
  logic             up_down;
  logic             sync_clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] Q;
  logic             terminal_count;
  logic             wrap;
  modport master(output count_enable, up_down, sync_clear, load, load_value,
                 input Q, terminal_count, wrap);
  modport slave(input count_enable, up_down, sync_clear, load, load_value,
                output Q, terminal_count, wrap);
endinterface

// File: rtl/jk_mod_counter_jk_ff.sv
// jk_ff: JK flip-flop with asynchronous active-low clear
module jk_ff (
  input  logic j,
  input  logic k,
  input  logic clear,
  input  logic clock,
  output logic q,
  output logic qb
);
  // hold, set, reset or toggle on each rising edge
  always_ff @(posedge clock or negedge clear)
    if (!clear) q <= 1'b0;
    else        q <= (j & k) ? ~q : j ? 1'b1 : k ? 1'b0 : q;
  assign qb = ~q;
endmodule

// File: rtl/jk_mod_counter.sv
// jk_mod_counter: up/down modulo-N counter tile built from JK flip-flops
module jk_mod_counter
  import jk_mod_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input logic              clock,
  input logic              clear,
  jk_mod_counter_if.slave  bus
);
  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   LP_MOD = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] LP_ONE = WIDTH'(1);
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qb;
  logic [WIDTH-1:0] w_next;
  logic             w_up;
  logic             w_tc;
  logic             r_wrap;
  assign w_up = (bus.up_down == CNT_UP);
  // A wrap happens exactly when this tile is at its terminal value and stepping,
  // so the cascade enable doubles as the next-state of the wrap flop.
  assign w_tc = bus.count_enable & ~bus.sync_clear & ~bus.load &
                (w_up ? (w_q == LP_MAX) : (w_q == '0));
  // next count: clear, then saturating load, then step (out-of-range recovers to 0), else hold
  always_comb
    w_next = bus.sync_clear   ? '0 :
             bus.load         ? (({1'b0, bus.load_value} >= LP_MOD) ? LP_MAX : bus.load_value) :
             bus.count_enable ? ((w_q > LP_MAX) ? '0 :
                                 w_up ? ((w_q == LP_MAX) ? '0 : w_q + LP_ONE) :
                                        ((w_q == '0) ? LP_MAX : w_q - LP_ONE)) :
             w_q;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_ff u_ff (
      .j     (w_next[i] & w_qb[i]),
      .k     (~w_next[i] & w_q[i]),
      .clear (clear),
      .clock (clock),
      .q     (w_q[i]),
      .qb    (w_qb[i])
    );
  end
  // one-cycle wrap pulse aligned with Q showing the wrapped value
  always_ff @(posedge clock or negedge clear)
    if (!clear) r_wrap <= 1'b0;
    else        r_wrap <= w_tc;
  assign bus.Q              = w_q;
  assign bus.terminal_count = w_tc;
  assign bus.wrap           = r_wrap;
endmodule

// File: tb/tb_jk_mod_counter.sv
// tb_jk_mod_counter: directed checks of a single tile and a two-tile cascade
module tb_jk_mod_counter;
  import jk_mod_counter_pkg::*;
  localparam int MOD = 10;
  localparam int W   = clog2(MOD);
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  jk_mod_counter_if #(.WIDTH(W)) if0 ();
  jk_mod_counter_if #(.WIDTH(W)) ic0 ();
  jk_mod_counter_if #(.WIDTH(W)) ic1 ();
  jk_mod_counter #(.WIDTH(W), .MODULUS(MOD)) dut  (.clock(clk), .clear(rst_n), .bus(if0));
  jk_mod_counter #(.WIDTH(W), .MODULUS(MOD)) dut0 (.clock(clk), .clear(rst_n), .bus(ic0));
  jk_mod_counter #(.WIDTH(W), .MODULUS(MOD)) dut1 (.clock(clk), .clear(rst_n), .bus(ic1));
  assign ic1.count_enable = ic0.terminal_count;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (if0.Q !== 4'd0) begin failures++; $display("FAIL reset_q: got %0d expected 0", if0.Q); end
    checks++; if (if0.wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap: got %b expected 0", if0.wrap); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (if0.Q !== 4'd0) begin failures++; $display("FAIL reset_release_q: got %0d expected 0", if0.Q); end
  endtask

  task automatic test_count_up();
    if0.up_down = CNT_UP;
    if0.count_enable = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      checks++;
      if (if0.terminal_count !== ((i - 1) == 9)) begin
        failures++; $display("FAIL up_tc step %0d: got %b expected %b", i, if0.terminal_count, (i - 1) == 9);
      end
      tick();
      checks++;
      if (if0.Q !== 4'(i % MOD)) begin failures++; $display("FAIL up_q step %0d: got %0d expected %0d", i, if0.Q, i % MOD); end
      checks++;
      if (if0.wrap !== (i == 10)) begin failures++; $display("FAIL up_wrap step %0d: got %b expected %b", i, if0.wrap, i == 10); end
    end
    if0.count_enable = 1'b0;
  endtask

  task automatic test_count_down();
    logic [3:0] exp_q [3];
    logic       exp_w [3];
    exp_q = '{4'd9, 4'd8, 4'd7};
    exp_w = '{1'b1, 1'b0, 1'b0};
    if0.sync_clear = 1'b1;
    tick();
    if0.sync_clear = 1'b0;
    checks++; if (if0.Q !== 4'd0) begin failures++; $display("FAIL down_start_q: got %0d expected 0", if0.Q); end
    if0.up_down = CNT_DOWN;
    if0.count_enable = 1'b1;
    #1;
    checks++; if (if0.terminal_count !== 1'b1) begin failures++; $display("FAIL down_tc: got %b expected 1", if0.terminal_count); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (if0.Q !== exp_q[i]) begin failures++; $display("FAIL down_q step %0d: got %0d expected %0d", i, if0.Q, exp_q[i]); end
      checks++; if (if0.wrap !== exp_w[i]) begin failures++; $display("FAIL down_wrap step %0d: got %b expected %b", i, if0.wrap, exp_w[i]); end
    end
    if0.count_enable = 1'b0;
  endtask

  task automatic test_load_saturate();
    if0.up_down = CNT_UP;
    if0.count_enable = 1'b1;
    if0.load = 1'b1;
    if0.load_value = 4'd13;
    #1;
    checks++; if (if0.terminal_count !== 1'b0) begin failures++; $display("FAIL load_tc: got %b expected 0", if0.terminal_count); end
    tick();
    checks++; if (if0.Q !== 4'd9) begin failures++; $display("FAIL load_sat_q: got %0d expected 9", if0.Q); end
    checks++; if (if0.wrap !== 1'b0) begin failures++; $display("FAIL load_sat_wrap: got %b expected 0", if0.wrap); end
    if0.load_value = 4'd3;
    tick();
    checks++; if (if0.Q !== 4'd3) begin failures++; $display("FAIL load_plain_q: got %0d expected 3", if0.Q); end
    if0.load = 1'b0;
    if0.count_enable = 1'b0;
  endtask

  task automatic test_clear_priority();
    if0.load = 1'b1;
    if0.load_value = 4'd7;
    tick();
    checks++; if (if0.Q !== 4'd7) begin failures++; $display("FAIL prio_load7_q: got %0d expected 7", if0.Q); end
    if0.sync_clear = 1'b1;
    if0.load_value = 4'd5;
    tick();
    checks++; if (if0.Q !== 4'd0) begin failures++; $display("FAIL prio_clear_q: got %0d expected 0", if0.Q); end
    if0.sync_clear = 1'b0;
    if0.load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (if0.Q !== 4'd0) begin failures++; $display("FAIL hold_q cycle %0d: got %0d expected 0", i, if0.Q); end
      checks++; if (if0.wrap !== 1'b0) begin failures++; $display("FAIL hold_wrap cycle %0d: got %b expected 0", i, if0.wrap); end
    end
  endtask

  task automatic test_async_clear();
    if0.up_down = CNT_DOWN;
    if0.count_enable = 1'b1;
    tick();
    if0.count_enable = 1'b0;
    checks++; if (if0.Q !== 4'd9) begin failures++; $display("FAIL async_pre_q: got %0d expected 9", if0.Q); end
    checks++; if (if0.wrap !== 1'b1) begin failures++; $display("FAIL async_pre_wrap: got %b expected 1", if0.wrap); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (if0.Q !== 4'd0) begin failures++; $display("FAIL async_q: got %0d expected 0", if0.Q); end
    checks++; if (if0.wrap !== 1'b0) begin failures++; $display("FAIL async_wrap: got %b expected 0", if0.wrap); end
    #1;
    rst_n = 1'b1;
    tick();
    checks++; if (if0.Q !== 4'd0) begin failures++; $display("FAIL async_release_q: got %0d expected 0", if0.Q); end
  endtask

  task automatic test_cascade();
    ic0.up_down = CNT_UP;
    ic1.up_down = CNT_UP;
    ic0.count_enable = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      checks++;
      if ({ic1.Q, ic0.Q} !== {4'(i / MOD), 4'(i % MOD)}) begin
        failures++; $display("FAIL cascade step %0d: got %0d,%0d expected %0d,%0d", i, ic1.Q, ic0.Q, i / MOD, i % MOD);
      end
    end
    ic0.count_enable = 1'b0;
    tick();
    checks++; if ({ic1.Q, ic0.Q} !== {4'd2, 4'd5}) begin failures++; $display("FAIL cascade_final: got %0d,%0d expected 2,5", ic1.Q, ic0.Q); end
  endtask

  initial begin
    rst_n = 1'b0;
    if0.count_enable = 1'b0; if0.up_down = CNT_UP; if0.sync_clear = 1'b0; if0.load = 1'b0; if0.load_value = '0;
    ic0.count_enable = 1'b0; ic0.up_down = CNT_UP; ic0.sync_clear = 1'b0; ic0.load = 1'b0; ic0.load_value = '0;
    ic1.up_down = CNT_UP; ic1.sync_clear = 1'b0; ic1.load = 1'b0; ic1.load_value = '0;
    test_reset();
    test_count_up();
    test_count_down();
    test_load_saturate();
    test_clear_priority();
    test_async_clear();
    test_cascade();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
